// File: rtl/bsg_swap_restore.sv
// bsg_swap_restore
// Return-path partner of a compare-and-swap stage. Tags recording whether the
// forward stage swapped each pair are queued in order. When a data pair comes
// back it is matched with the oldest tag, swapped back if the tag says so, and
// presented through a one-entry registered output stage.
module bsg_swap_restore #(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic                         tag_v_i,
  input  logic                         tag_i,
  output logic                         tag_ready_o,

  input  logic                         data_v_i,
  input  logic [2*width_p-1:0]         data_i,
  output logic                         data_ready_o,

  output logic                         data_v_o,
  output logic [2*width_p-1:0]         data_o,
  output logic                         swapped_o,
  input  logic                         ready_i,

  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [cnt_w_lp-1:0] els_lp      = cnt_w_lp'(els_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

  logic [els_p-1:0]      tags_r;
  logic [ptr_w_lp-1:0]   wr_ptr_r;
  logic [ptr_w_lp-1:0]   rd_ptr_r;
  logic [cnt_w_lp-1:0]   count_r;

  logic                  data_v_r;
  logic [2*width_p-1:0]  data_r;
  logic                  swapped_r;

  logic                  enq;
  logic                  deq;
  logic                  head_tag;
  logic [2*width_p-1:0]  restored;

  // A full queue refuses new tags outright; there is no pass-through even when
  // the head is being consumed in the same cycle.
  assign tag_ready_o  = (count_r != els_lp);
  // A pair is taken only against a tag already stored, and only when the
  // output register is empty or draining this cycle.
  assign data_ready_o = (count_r != '0) && (!data_v_r || ready_i);

  assign enq      = tag_v_i  && tag_ready_o;
  assign deq      = data_v_i && data_ready_o;
  assign head_tag = tags_r[rd_ptr_r];

  // Undo the forward swap: lanes return as {hi, lo}; a set tag exchanges them.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves the
    // output unassigned; a missing branch would otherwise infer a latch.
    restored = data_i;
    if (head_tag) begin
      restored = {data_i[width_p-1:0], data_i[2*width_p-1:width_p]};
    end
  end

  // Tag storage, written at the tail.
  // NOTE: the storage array has no reset; only pointers and count define which
  // entries are live, so clearing the array would buy nothing.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      tags_r[wr_ptr_r] <= tag_i;
    end
  end

  // Queue pointers and occupancy; pointers wrap at els_p-1 for any depth.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      // NOTE: non-blocking assignments for all registered state so every
      // flop samples the pre-edge values regardless of statement order.
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
      end
      if (deq) begin
        rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
      end
      if (enq && !deq) begin
        count_r <= count_r + 1'b1;
      end else if (deq && !enq) begin
        count_r <= count_r - 1'b1;
      end
    end
  end

  // Output register: load on acceptance, drop valid when drained without refill.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_v_r  <= 1'b0;
      data_r    <= '0;
      swapped_r <= 1'b0;
    end else if (deq) begin
      data_v_r  <= 1'b1;
      data_r    <= restored;
      swapped_r <= head_tag;
    end else if (ready_i) begin
      data_v_r  <= 1'b0;
    end
  end

  assign data_v_o  = data_v_r;
  assign data_o    = data_r;
  assign swapped_o = swapped_r;
  assign count_o   = count_r;

endmodule

// File: tb/tb_bsg_swap_restore.sv
// Directed, table-driven bench for bsg_swap_restore (width_p=16, els_p=4).
// Each vector is driven on the falling edge; the handshake readies are checked
// just after driving, the registered outputs just after the following rise.
module tb_bsg_swap_restore;

  localparam int width_p = 16;
  localparam int els_p   = 4;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        tag_v_i;
  logic        tag_i;
  logic        tag_ready_o;
  logic        data_v_i;
  logic [31:0] data_i;
  logic        data_ready_o;
  logic        data_v_o;
  logic [31:0] data_o;
  logic        swapped_o;
  logic        ready_i;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  bsg_swap_restore #(.width_p(width_p), .els_p(els_p)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .tag_v_i      (tag_v_i),
    .tag_i        (tag_i),
    .tag_ready_o  (tag_ready_o),
    .data_v_i     (data_v_i),
    .data_i       (data_i),
    .data_ready_o (data_ready_o),
    .data_v_o     (data_v_o),
    .data_o       (data_o),
    .swapped_o    (swapped_o),
    .ready_i      (ready_i),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        tv;
    logic        t;
    logic        dv;
    logic [31:0] d;
    logic        rdy;
    logic        e_tr;   // tag_ready_o before the edge
    logic        e_dr;   // data_ready_o before the edge
    logic [2:0]  e_cnt;  // count_o after the edge
    logic        e_vo;   // data_v_o after the edge
    logic [31:0] e_do;   // data_o after the edge
    logic        e_sw;   // swapped_o after the edge
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic tv, input logic t, input logic dv, input logic [31:0] d,
                     input logic rdy, input logic e_tr, input logic e_dr, input logic [2:0] e_cnt,
                     input logic e_vo, input logic [31:0] e_do, input logic e_sw);
    vec_t v;
    v.tv = tv; v.t = t; v.dv = dv; v.d = d; v.rdy = rdy;
    v.e_tr = e_tr; v.e_dr = e_dr; v.e_cnt = e_cnt;
    v.e_vo = e_vo; v.e_do = e_do; v.e_sw = e_sw;
    vq.push_back(v);
  endtask

  task automatic drive(input logic tv, input logic t, input logic dv,
                       input logic [31:0] d, input logic rdy);
    tag_v_i  = tv;
    tag_i    = t;
    data_v_i = dv;
    data_i   = d;
    ready_i  = rdy;
  endtask

  initial begin
    // Single restore, pass-through, full queue then drain, backpressure, no bypass.
    add(1,1,0,32'h0,          1, 1,0,3'd1,0,32'h0,          0);
    add(0,0,1,32'h1111_2222,  1, 1,1,3'd0,1,32'h2222_1111,  1);
    add(1,0,0,32'h0,          1, 1,0,3'd1,0,32'h2222_1111,  1);
    add(0,0,1,32'hABCD_0123,  1, 1,1,3'd0,1,32'hABCD_0123,  0);
    add(1,1,0,32'h0,          1, 1,0,3'd1,0,32'hABCD_0123,  0);
    add(1,0,0,32'h0,          1, 1,1,3'd2,0,32'hABCD_0123,  0);
    add(1,1,0,32'h0,          1, 1,1,3'd3,0,32'hABCD_0123,  0);
    add(1,1,0,32'h0,          1, 1,1,3'd4,0,32'hABCD_0123,  0);
    add(1,0,0,32'h0,          1, 0,1,3'd4,0,32'hABCD_0123,  0);
    add(1,0,1,32'hAAAA_BBBB,  1, 0,1,3'd3,1,32'hBBBB_AAAA,  1);
    add(0,0,1,32'h1234_5678,  1, 1,1,3'd2,1,32'h1234_5678,  0);
    add(0,0,1,32'hDEAD_BEEF,  1, 1,1,3'd1,1,32'hBEEF_DEAD,  1);
    add(0,0,1,32'h0F0F_F0F0,  1, 1,1,3'd0,1,32'hF0F0_0F0F,  1);
    add(0,0,0,32'h0,          1, 1,0,3'd0,0,32'hF0F0_0F0F,  1);
    add(1,1,0,32'h0,          1, 1,0,3'd1,0,32'hF0F0_0F0F,  1);
    add(1,0,1,32'h5555_6666,  1, 1,1,3'd1,1,32'h6666_5555,  1);
    add(0,0,1,32'h7777_8888,  0, 1,0,3'd1,1,32'h6666_5555,  1);
    add(0,0,1,32'h7777_8888,  0, 1,0,3'd1,1,32'h6666_5555,  1);
    add(0,0,1,32'h7777_8888,  1, 1,1,3'd0,1,32'h7777_8888,  0);
    add(0,0,0,32'h0,          1, 1,0,3'd0,0,32'h7777_8888,  0);
    add(1,1,1,32'h0102_0304,  1, 1,0,3'd1,0,32'h7777_8888,  0);
    add(0,0,1,32'h0102_0304,  1, 1,1,3'd0,1,32'h0304_0102,  1);

    // Reset held with random inputs.
    reset_n_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom));
      @(posedge clk_i); #1;
      check($sformatf("rst%0d count", i),   32'(count_o),  32'd0);
      check($sformatf("rst%0d data_v", i),  32'(data_v_o), 32'd0);
      check($sformatf("rst%0d data", i),    data_o,        32'd0);
      check($sformatf("rst%0d swapped", i), 32'(swapped_o), 32'd0);
    end
    @(negedge clk_i);
    drive(0, 0, 0, 32'h0, 1);
    reset_n_i = 1'b1;
    #1;
    check("post_rst tag_ready",  32'(tag_ready_o),  32'd1);
    check("post_rst data_ready", 32'(data_ready_o), 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_i);
      drive(vq[i].tv, vq[i].t, vq[i].dv, vq[i].d, vq[i].rdy);
      #1;
      check($sformatf("v%0d tag_ready", i),  32'(tag_ready_o),  32'(vq[i].e_tr));
      check($sformatf("v%0d data_ready", i), 32'(data_ready_o), 32'(vq[i].e_dr));
      @(posedge clk_i); #1;
      check($sformatf("v%0d count", i),   32'(count_o),   32'(vq[i].e_cnt));
      check($sformatf("v%0d data_v", i),  32'(data_v_o),  32'(vq[i].e_vo));
      check($sformatf("v%0d data", i),    data_o,         vq[i].e_do);
      check($sformatf("v%0d swapped", i), 32'(swapped_o), 32'(vq[i].e_sw));
    end

    // Mid-stream asynchronous reset: output held valid, two tags queued.
    @(negedge clk_i);
    drive(1, 0, 0, 32'h0, 0);
    @(negedge clk_i);
    drive(1, 1, 0, 32'h0, 0);
    @(posedge clk_i); #1;
    check("pre_arst count",  32'(count_o),  32'd2);
    check("pre_arst data_v", 32'(data_v_o), 32'd1);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("arst data_v",  32'(data_v_o),  32'd0);
    check("arst count",   32'(count_o),   32'd0);
    check("arst data",    data_o,         32'd0);
    check("arst swapped", 32'(swapped_o), 32'd0);
    @(negedge clk_i);
    drive(0, 0, 1, 32'h9999_AAAA, 1);
    reset_n_i = 1'b1;
    #1;
    check("arst_rel tag_ready",  32'(tag_ready_o),  32'd1);
    check("arst_rel data_ready", 32'(data_ready_o), 32'd0);
    @(posedge clk_i); #1;
    check("arst_rel data_v", 32'(data_v_o), 32'd0);

    // Queue works again after reset: tag then pair.
    @(negedge clk_i);
    drive(1, 1, 0, 32'h0, 1);
    @(posedge clk_i); #1;
    check("after_arst count", 32'(count_o), 32'd1);
    @(negedge clk_i);
    drive(0, 0, 1, 32'h9999_AAAA, 1);
    @(posedge clk_i); #1;
    check("after_arst data",  data_o,        32'hAAAA_9999);
    check("after_arst count2", 32'(count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
